// File: rtl/bram_dbg_pkg.sv
// rtl/bram_dbg_pkg.sv - shared types and constants for the BRAM debug engine
package bram_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_FIN
    } state_t;

    localparam logic       OP_LOAD    = 1'b0;
    localparam logic       OP_DUMP    = 1'b1;
    localparam logic [3:0] WE_ALL     = 4'hF;
    localparam int         RD_LATENCY = 1;

    // A single-channel build still needs a 1-bit channel select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_debug_engine_if.sv
// rtl/bram_debug_engine_if.sv - host command, load and dump streams
interface bram_debug_engine_if
    import bram_dbg_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 13
) ();
    localparam int CH_W = ch_width(NUM_CH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [CH_W-1:0]  cmd_ch;
    logic [31:0]      cmd_base;
    logic [CNT_W-1:0] cmd_count;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_data;
    logic [31:0]      rd_addr;
    logic             hold_cpu;
    logic             done;
    logic             err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_ch, cmd_base, cmd_count, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_addr, hold_cpu, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_ch, cmd_base, cmd_count, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_addr, hold_cpu, done, err
    );

endinterface

// File: rtl/bram_dbg_chan_mux.sv
// rtl/bram_dbg_chan_mux.sv - steers one access onto the selected debug port, selects read data
module bram_dbg_chan_mux #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [CH_W-1:0]     i_ch,
    input  logic [31:0]         i_a,
    input  logic [31:0]         i_wd,
    input  logic [3:0]          i_we,
    input  logic [CH_W-1:0]     i_rd_ch,
    input  logic [NUM_CH*32-1:0] i_rd2,
    output logic [NUM_CH*32-1:0] o_a2,
    output logic [NUM_CH*32-1:0] o_wd2,
    output logic [NUM_CH*4-1:0]  o_we2,
    output logic [31:0]          o_rd
);
    logic [NUM_CH*32-1:0] w_a2;
    logic [NUM_CH*32-1:0] w_wd2;
    logic [NUM_CH*4-1:0]  w_we2;
    logic [NUM_CH*32-1:0] r_a2;
    logic [NUM_CH*32-1:0] r_wd2;
    logic [NUM_CH*4-1:0]  r_we2;

    always_comb begin
        w_a2  = '0;
        w_wd2 = '0;
        w_we2 = '0;
        o_rd  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_en && int'(i_ch) == i) begin
                w_a2[i*32 +: 32] = i_a;
                w_wd2[i*32 +: 32] = i_wd;
                w_we2[i*4 +: 4]  = i_we;
            end
            if (int'(i_rd_ch) == i) begin
                o_rd = i_rd2[i*32 +: 32];
            end
        end
    end

    // Async clear drops every write enable the instant reset is asserted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a2  <= '0;
            r_wd2 <= '0;
            r_we2 <= '0;
        end else begin
            r_a2  <= w_a2;
            r_wd2 <= w_wd2;
            r_we2 <= w_we2;
        end
    end

    assign o_a2  = r_a2;
    assign o_wd2 = r_wd2;
    assign o_we2 = r_we2;

endmodule

// File: rtl/bram_debug_engine.sv
// rtl/bram_debug_engine.sv - load/dump engine driving BRAM debug ports while holding the core
module bram_debug_engine
    import bram_dbg_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int BRAM_WORDS = 4096,
    parameter int CNT_W      = 13
) (
    input  logic                  CPU_CLK,
    input  logic                  CPU_RST,
    bram_debug_engine_if.slave    host,
    output logic [NUM_CH*32-1:0]  dbg_a2,
    output logic [NUM_CH*32-1:0]  dbg_wd2,
    output logic [NUM_CH*4-1:0]   dbg_we2,
    input  logic [NUM_CH*32-1:0]  dbg_rd2
);
    localparam int CH_W = ch_width(NUM_CH);

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_count;
    logic [CH_W-1:0]  r_ch;
    logic             r_err;
    logic             r_rd_valid;
    logic [31:0]      r_rd_data;
    logic [31:0]      r_rd_addr;

    logic             w_cmd_ok;
    logic [31:0]      w_end_word;
    logic             w_last;
    logic             w_acc_en;
    logic [CH_W-1:0]  w_acc_ch;
    logic [31:0]      w_acc_a;
    logic [31:0]      w_acc_wd;
    logic [3:0]       w_acc_we;
    logic [31:0]      w_rd_sel;

    assign w_end_word = {2'b00, host.cmd_base[31:2]} + 32'(host.cmd_count);
    assign w_cmd_ok   = (host.cmd_count != '0) && (host.cmd_base[1:0] == 2'b00) &&
                        (int'(host.cmd_ch) < NUM_CH) && (w_end_word <= 32'(BRAM_WORDS));
    assign w_last     = (r_count == CNT_W'(1));

    // The port registers sit one cycle ahead, so a read address must be
    // presented on the transition into RD_ISSUE, not during it.
    always_comb begin
        w_acc_en = 1'b0;
        w_acc_ch = r_ch;
        w_acc_a  = '0;
        w_acc_wd = '0;
        w_acc_we = '0;
        case (r_state)
            S_IDLE: begin
                if (host.cmd_valid && w_cmd_ok && host.cmd_op == OP_DUMP) begin
                    w_acc_en = 1'b1;
                    w_acc_ch = host.cmd_ch;
                    w_acc_a  = host.cmd_base;
                end
            end
            S_LOAD: begin
                if (host.wr_valid) begin
                    w_acc_en = 1'b1;
                    w_acc_a  = r_addr;
                    w_acc_wd = host.wr_data;
                    w_acc_we = WE_ALL;
                end
            end
            S_RD_OUT: begin
                if (host.rd_ready && !w_last) begin
                    w_acc_en = 1'b1;
                    w_acc_a  = r_addr + 32'd4;
                end
            end
            default: ;
        endcase
    end

    bram_dbg_chan_mux #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_mux (
        .i_clk   (CPU_CLK),
        .i_rst   (CPU_RST),
        .i_en    (w_acc_en),
        .i_ch    (w_acc_ch),
        .i_a     (w_acc_a),
        .i_wd    (w_acc_wd),
        .i_we    (w_acc_we),
        .i_rd_ch (r_ch),
        .i_rd2   (dbg_rd2),
        .o_a2    (dbg_a2),
        .o_wd2   (dbg_wd2),
        .o_we2   (dbg_we2),
        .o_rd    (w_rd_sel)
    );

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_ch       <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (host.cmd_valid) begin
                        r_ch    <= host.cmd_ch;
                        r_addr  <= host.cmd_base;
                        r_count <= host.cmd_count;
                        if (!w_cmd_ok) begin
                            r_err   <= 1'b1;
                            r_state <= S_FIN;
                        end else if (host.cmd_op == OP_LOAD) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_LOAD: begin
                    if (host.wr_valid) r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_count <= r_count - CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_FIN;
                    end else begin
                        r_addr  <= r_addr + 32'd4;
                        r_state <= S_LOAD;
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_rd_data  <= w_rd_sel;
                    r_rd_addr  <= r_addr;
                    r_rd_valid <= 1'b1;
                    r_state    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (host.rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_count    <= r_count - CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_addr  <= r_addr + 32'd4;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host.cmd_ready = (r_state == S_IDLE);
    assign host.wr_ready  = (r_state == S_LOAD);
    assign host.hold_cpu  = (r_state != S_IDLE);
    assign host.done      = (r_state == S_FIN);
    assign host.err       = (r_state == S_FIN) && r_err;
    assign host.rd_valid  = r_rd_valid;
    assign host.rd_data   = r_rd_data;
    assign host.rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_bram_debug_engine.sv
// tb/tb_bram_debug_engine.sv - self-checking bench for bram_debug_engine
module tb_bram_debug_engine;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b1;
    logic [63:0] dbg_a2;
    logic [63:0] dbg_wd2;
    logic [7:0]  dbg_we2;
    logic [63:0] dbg_rd2 = '0;

    always #5 CPU_CLK = ~CPU_CLK;

    bram_debug_engine_if #(.NUM_CH(2), .CNT_W(13)) host_if ();

    bram_debug_engine #(.NUM_CH(2), .BRAM_WORDS(4096), .CNT_W(13)) dut (
        .CPU_CLK (CPU_CLK),
        .CPU_RST (CPU_RST),
        .host    (host_if),
        .dbg_a2  (dbg_a2),
        .dbg_wd2 (dbg_wd2),
        .dbg_we2 (dbg_we2),
        .dbg_rd2 (dbg_rd2)
    );

    typedef struct { int ch; logic [31:0] a; logic [31:0] d; logic [3:0] we; } wr_ev_t;

    logic [31:0] bram    [0:1][0:4095];
    logic [31:0] ref_mem [0:1][0:4095];
    logic [31:0] ld_data [0:4095];
    logic [31:0] rd_dat  [0:4095];
    logic [31:0] rd_adr  [0:4095];
    wr_ev_t      wr_log[$];
    int n_pass = 0, n_total = 0;
    int hold_viol = 0, stab_viol = 0, mux_viol = 0, oob = 0;
    int rd_n = 0, first_hs_seen = -1;
    logic post_ok = 1'b0;

    // 1-cycle synchronous BRAM behind each debug port
    always @(posedge CPU_CLK) begin
        for (int c = 0; c < 2; c++) begin
            logic [31:0] a;
            a = dbg_a2[c*32 +: 32];
            if (a >= 32'h4000) oob++;
            dbg_rd2[c*32 +: 32] <= bram[c][a[13:2]];
            if (dbg_we2[c*4 +: 4] != 4'h0 && a < 32'h4000) bram[c][a[13:2]] = dbg_wd2[c*32 +: 32];
        end
    end

    always @(negedge CPU_CLK) begin
        int act;
        act = 0;
        for (int c = 0; c < 2; c++) begin
            if (dbg_a2[c*32 +: 32] != 0 || dbg_wd2[c*32 +: 32] != 0 || dbg_we2[c*4 +: 4] != 0) act++;
            if (dbg_we2[c*4 +: 4] != 4'h0)
                wr_log.push_back('{c, dbg_a2[c*32 +: 32], dbg_wd2[c*32 +: 32], dbg_we2[c*4 +: 4]});
        end
        if (act > 1) mux_viol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic exp_reject(input int ch, input logic [31:0] base, input int cnt);
        return (cnt == 0) || (base[1:0] != 2'b00) || (ch >= 2) ||
               ((longint'(base >> 2) + longint'(cnt)) > 64'd4096);
    endfunction

    task automatic run_cmd(input logic op, input int ch, input logic [31:0] base, input int cnt,
                           input int stall, input int rdy_low, output int lat, output logic got_err);
        int widx, seen, budget;
        logic pv, fin;
        logic [31:0] pd, pa;
        widx = 0; seen = 0; pv = 0; fin = 0; pd = 0; pa = 0;
        rd_n = 0; first_hs_seen = -1; got_err = 0;
        budget = cnt * 8 + 40;
        @(negedge CPU_CLK);
        wr_log.delete();
        host_if.cmd_op    = op;
        host_if.cmd_ch    = ch[0];
        host_if.cmd_base  = base;
        host_if.cmd_count = cnt[12:0];
        host_if.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && host_if.cmd_ready !== 1'b1; k++) @(negedge CPU_CLK);
        @(negedge CPU_CLK);
        host_if.cmd_valid = 1'b0;
        lat = 1;
        while (lat <= budget) begin
            if (host_if.hold_cpu !== 1'b1) hold_viol++;
            if (host_if.done === 1'b1) begin
                got_err = host_if.err;
                fin = 1;
                break;
            end
            host_if.wr_valid = (widx < cnt) && ($urandom_range(99) >= stall);
            host_if.wr_data  = (widx < 4096) ? ld_data[widx] : 32'h0;
            host_if.rd_ready = (seen >= rdy_low) && ($urandom_range(99) >= stall);
            if (host_if.wr_valid && host_if.wr_ready === 1'b1) widx++;
            if (host_if.rd_valid === 1'b1) begin
                seen++;
                if (pv && (host_if.rd_data !== pd || host_if.rd_addr !== pa)) stab_viol++;
                if (host_if.rd_ready) begin
                    if (first_hs_seen < 0) first_hs_seen = seen;
                    if (rd_n < 4096) begin
                        rd_dat[rd_n] = host_if.rd_data;
                        rd_adr[rd_n] = host_if.rd_addr;
                    end
                    rd_n++;
                    pv = 0;
                end else begin
                    pv = 1; pd = host_if.rd_data; pa = host_if.rd_addr;
                end
            end else begin
                pv = 0;
            end
            @(negedge CPU_CLK);
            lat++;
        end
        host_if.wr_valid = 1'b0;
        host_if.rd_ready = 1'b0;
        if (!fin) lat = -1;
        @(negedge CPU_CLK);
        post_ok = (host_if.done === 1'b0) && (host_if.hold_cpu === 1'b0) && (host_if.cmd_ready === 1'b1);
    endtask

    task automatic check_load(input string tag, input int ch, input logic [31:0] base, input int cnt);
        int bad;
        bad = 0;
        chk({tag, "_nwr"}, wr_log.size(), cnt);
        for (int i = 0; i < wr_log.size(); i++) begin
            if (i >= cnt || wr_log[i].ch != ch || wr_log[i].a !== base + 32'(4 * i) ||
                wr_log[i].d !== ld_data[i] || wr_log[i].we !== 4'hF) bad++;
        end
        chk({tag, "_wr"}, bad, 0);
        for (int i = 0; i < cnt; i++) ref_mem[ch][int'(base >> 2) + i] = ld_data[i];
    endtask

    task automatic check_dump(input string tag, input int ch, input logic [31:0] base, input int cnt);
        int bad;
        bad = 0;
        chk({tag, "_nrd"}, rd_n, cnt);
        for (int i = 0; i < rd_n && i < cnt; i++) begin
            if (rd_dat[i] !== ref_mem[ch][int'(base >> 2) + i] || rd_adr[i] !== base + 32'(4 * i)) bad++;
        end
        chk({tag, "_rd"}, bad, 0);
        chk({tag, "_nowr"}, wr_log.size(), 0);
    endtask

    initial begin
        int lat, widx, saw_done, cnt, ch;
        logic e, rj, op, hit;
        logic [31:0] base;
        logic [31:0] rj_base [0:4];
        int          rj_cnt  [0:4];
        rj_base = '{32'h0, 32'h2, 32'h3FFC, 32'h3, 32'h3FFC};
        rj_cnt  = '{0, 1, 2, 1, 1};
        for (int c = 0; c < 2; c++)
            for (int w = 0; w < 4096; w++) begin bram[c][w] = '0; ref_mem[c][w] = '0; end
        host_if.cmd_valid = 0; host_if.cmd_op = 0; host_if.cmd_ch = 0;
        host_if.cmd_base = 0; host_if.cmd_count = 0;
        host_if.wr_valid = 0; host_if.wr_data = 0; host_if.rd_ready = 0;
        repeat (3) @(negedge CPU_CLK);
        CPU_RST = 1'b0;
        @(negedge CPU_CLK);
        chk("rst_cmd_ready", host_if.cmd_ready, 1);
        chk("rst_wr_ready", host_if.wr_ready, 0);
        chk("rst_rd_valid", host_if.rd_valid, 0);
        chk("rst_rd_data", host_if.rd_data, 0);
        chk("rst_rd_addr", host_if.rd_addr, 0);
        chk("rst_a2", dbg_a2, 0);
        chk("rst_wd2", dbg_wd2, 0);
        chk("rst_we2", dbg_we2, 0);
        chk("rst_hold", host_if.hold_cpu, 0);
        chk("rst_done", host_if.done, 0);
        chk("rst_err", host_if.err, 0);

        for (int i = 0; i < 4; i++) ld_data[i] = 32'h11111111 * 32'(i + 1);
        run_cmd(1'b0, 0, 32'h0, 4, 0, 0, lat, e);
        chk("t1_lat", lat, 9);
        chk("t1_err", e, 0);
        chk("t1_post", post_ok, 1);
        check_load("t1", 0, 32'h0, 4);

        run_cmd(1'b1, 0, 32'h4, 3, 0, 0, lat, e);
        chk("t1d_lat", lat, 10);
        check_dump("t1d", 0, 32'h4, 3);

        bram[1][4] = 32'hDEADBEEF;
        ref_mem[1][4] = 32'hDEADBEEF;
        run_cmd(1'b1, 1, 32'h10, 1, 0, 5, lat, e);
        chk("t2_data", rd_dat[0], 32'hDEADBEEF);
        chk("t2_addr", rd_adr[0], 32'h10);
        chk("t2_wait", first_hs_seen, 6);
        chk("t2_stable", stab_viol, 0);
        chk("t2_lat", lat, 9);
        chk("t2_err", e, 0);

        for (int i = 0; i < 4096; i++) ld_data[i] = $urandom;
        run_cmd(1'b0, 1, 32'h0, 4096, 20, 0, lat, e);
        chk("t3_load_err", e, 0);
        check_load("t3_load", 1, 32'h0, 4096);
        run_cmd(1'b1, 1, 32'h0, 4096, 20, 0, lat, e);
        chk("t3_dump_err", e, 0);
        check_dump("t3_dump", 1, 32'h0, 4096);
        chk("t3_last_addr", rd_adr[4095], 32'h3FFC);
        chk("t3_oob", oob, 0);

        for (int r = 0; r < 5; r++) begin
            ld_data[0] = $urandom;
            rj = exp_reject(0, rj_base[r], rj_cnt[r]);
            run_cmd(1'b0, 0, rj_base[r], rj_cnt[r], 0, 0, lat, e);
            chk($sformatf("t4_err_%0d", r), e, rj);
            chk($sformatf("t4_lat_%0d", r), lat, rj ? 1 : 2 * rj_cnt[r] + 1);
            if (rj) chk($sformatf("t4_nowr_%0d", r), wr_log.size(), 0);
            else check_load($sformatf("t4_%0d", r), 0, rj_base[r], rj_cnt[r]);
        end

        for (int i = 0; i < 8; i++) ld_data[i] = $urandom;
        @(negedge CPU_CLK);
        host_if.cmd_op = 1'b0; host_if.cmd_ch = 1'b0;
        host_if.cmd_base = 32'h100; host_if.cmd_count = 13'd8; host_if.cmd_valid = 1'b1;
        @(negedge CPU_CLK);
        host_if.cmd_valid = 1'b0;
        widx = 0; hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (dbg_we2[3:0] === 4'hF && dbg_a2[31:0] === 32'h104) begin
                hit = 1;
            end else begin
                host_if.wr_valid = 1'b1;
                host_if.wr_data  = ld_data[widx];
                if (host_if.wr_ready === 1'b1) widx++;
                @(negedge CPU_CLK);
            end
        end
        chk("t5_reached_word2", hit, 1);
        ref_mem[0][64] = ld_data[0];
        #1 CPU_RST = 1'b1;
        #1;
        chk("t5_we2_async", dbg_we2, 0);
        chk("t5_a2_async", dbg_a2, 0);
        chk("t5_hold", host_if.hold_cpu, 0);
        chk("t5_cmd_ready", host_if.cmd_ready, 1);
        host_if.wr_valid = 1'b0;
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;
        saw_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (host_if.done === 1'b1) saw_done++;
            @(negedge CPU_CLK);
        end
        chk("t5_no_done", saw_done, 0);
        chk("t5_word2_unwritten", bram[0][65], ref_mem[0][65]);
        run_cmd(1'b0, 0, 32'h100, 2, 0, 0, lat, e);
        chk("t5_fresh_lat", lat, 5);
        chk("t5_fresh_err", e, 0);
        check_load("t5_fresh", 0, 32'h100, 2);

        for (int it = 0; it < 10; it++) begin
            op  = 1'($urandom_range(1));
            ch  = int'($urandom_range(1));
            cnt = int'($urandom_range(6));
            case ($urandom_range(3))
                0:       base = 32'h3FF0 + 32'(4 * $urandom_range(3));
                1:       base = 32'(4 * $urandom_range(64)) | 32'($urandom_range(3, 1));
                default: base = 32'(4 * $urandom_range(64));
            endcase
            for (int i = 0; i < 8; i++) ld_data[i] = $urandom;
            rj = exp_reject(ch, base, cnt);
            run_cmd(op, ch, base, cnt, 0, 0, lat, e);
            chk($sformatf("rnd%0d_err", it), e, rj);
            chk($sformatf("rnd%0d_lat", it), lat, rj ? 1 : (op ? 3 * cnt + 1 : 2 * cnt + 1));
            if (rj) chk($sformatf("rnd%0d_nowr", it), wr_log.size(), 0);
            else if (op == 1'b0) check_load($sformatf("rnd%0d", it), ch, base, cnt);
            else check_dump($sformatf("rnd%0d", it), ch, base, cnt);
        end

        chk("end_hold", hold_viol, 0);
        chk("end_mux", mux_viol, 0);
        chk("end_oob", oob, 0);
        chk("end_stable", stab_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bram_debug_engine.md
# bram_debug_engine

Synthesizable replacement for the simulation-only loader/dumper that fills and reads back the core's BRAMs through their debug ports (A2/WD2/WE2/RD2). Accepts load/dump commands over a valid/ready handshake, streams words in or out, and drives any of NUM_CH BRAM debug ports. Sits between a host link (UART/JTAG bridge) and RV32Core, and holds the core in reset while it works.

## Interface
- NUM_CH, 2, number of BRAM debug ports (0 = DataRAM, 1 = InstRAM)
- BRAM_WORDS, 4096, 32-bit words per BRAM
- CNT_W, 13, width of the word count (must hold BRAM_WORDS)

- CPU_CLK  in  1  sole clock
- CPU_RST  in  1  reset, asynchronous, active-high
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_op  in  1  0 = load, 1 = dump
- cmd_ch  in  $clog2(NUM_CH)  target BRAM
- cmd_base  in  32  byte start address
- cmd_count  in  CNT_W  words to transfer
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / 32  load data stream
- rd_valid / rd_ready / rd_data / rd_addr  out / in / out / out  1 / 1 / 32 / 32  dump data stream
- dbg_a2  out  NUM_CH*32  per-channel debug address
- dbg_wd2  out  NUM_CH*32  per-channel write data
- dbg_we2  out  NUM_CH*4  per-channel byte enables
- dbg_rd2  in  NUM_CH*32  per-channel read data (1-cycle synchronous BRAM read)
- hold_cpu  out  1  high while a command is in progress; drives core reset
- done / err  out  1 / 1  one-cycle completion and error pulses

## Operation
- States: IDLE, LOAD, WRITE, RD_ISSUE, RD_WAIT, RD_OUT, FIN.
- IDLE: cmd_ready = 1. On cmd_valid, latch the command and validate it.
- Invalid command: count = 0, base[1:0] != 0, cmd_ch >= NUM_CH, or base/4 + count > BRAM_WORDS. Go to FIN with err set and make no RAM access.
- LOAD: wr_ready = 1. A word is accepted on wr_valid & wr_ready. Go to WRITE.
- WRITE: on the selected channel, drive a2 = current address, wd2 = the word, we2 = 4'hF for exactly one cycle. Then increment the address by 4 and decrement the remaining count. Go to LOAD, or to FIN if the count reaches 0.
- RD_ISSUE: drive a2 = current address, we2 = 0. Go to RD_WAIT.
- RD_WAIT: capture dbg_rd2 of the channel into rd_data, and the address into rd_addr. Go to RD_OUT.
- RD_OUT: rd_valid = 1. Hold rd_data/rd_addr stable until rd_ready. On handshake, advance the address and count, then go to RD_ISSUE, or to FIN after the last word.
- FIN: done = 1 for one cycle, err = 1 in the same cycle if the command was rejected. Return to IDLE.
- Unselected channels always see we2 = 0 and a2/wd2 = 0.
- hold_cpu = (state != IDLE).
- Counts never wrap. An address is only generated inside the validated range.

## Timing
- Reset values: state IDLE, cmd_ready 1, wr_ready 0, rd_valid 0, rd_data/rd_addr 0, all dbg_* 0, hold_cpu 0, done 0, err 0.
- Asserting reset mid-command aborts immediately (asynchronous): we2 drops to 0 without waiting for a clock, and the partial transfer is not reported.
- All dbg_* outputs and rd_* outputs are registered. wr_ready, cmd_ready and hold_cpu are decoded from state.
- Load: 2 cycles per word minimum, command-accept to done = 2·count + 1 cycles with wr_valid held high.
- Dump: 3 cycles per word minimum with rd_ready high, plus FIN.
- Reject: cmd handshake -> done & err on the following cycle.
- A new command is accepted no earlier than the cycle after FIN.
- wr_valid and rd_ready are ignored outside LOAD and RD_OUT respectively.

## Structure
- Shared package bram_dbg_pkg holds the state enum, the op encoding (OP_LOAD = 0, OP_DUMP = 1), the byte-enable constant WE_ALL = 4'hF, and the BRAM read-latency constant (1).
- One sub-module, bram_dbg_chan_mux, steers a2/wd2/we2 to the selected channel and selects the returning rd2. It is purely combinational plus an output register.
- Everything else is one FSM plus address and count registers in the top module.

## Test plan
- Load ch0, base 0x0, count 4, data 0x11111111..0x44444444, wr_valid held high -> four 1-cycle we2 = F pulses at a2 0,4,8,C; done at cycle 9; ch1 we2 stays 0.
- Dump ch1 (model preloaded with 0xDEADBEEF at 0x10), base 0x10, count 1, rd_ready low for 5 cycles -> rd_valid held with rd_data 0xDEADBEEF, rd_addr 0x10 stable; done after the handshake.
- Load then dump 4096 words on ch1 -> readback matches, last rd_addr 0x3FFC, no address beyond range.
- Reject cases: count 0; base 0x2; base 0x3FFC with count 2; ch 2 with NUM_CH = 2 -> done & err the cycle after accept, all we2 remain 0.
- Reset pulsed during WRITE of word 2 of 8 -> we2 0 asynchronously, hold_cpu 0, cmd_ready 1, no done; a fresh command is then accepted normally.
- hold_cpu: high from the cycle after cmd accept through FIN, low otherwise.
